// File: rtl/cpu_pkg.sv
// Shared execute-stage types: decoded ALU controls, compare flags, ALU FSM states
// and the control-priority decoder.
package cpu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef struct packed {
    logic isAdd;
    logic isSub;
    logic isCmp;
    logic isMul;
    logic isDiv;
    logic isMod;
    logic isLsl;
    logic isLsr;
    logic isAsr;
    logic isOr;
    logic isAnd;
    logic isNot;
    logic isMov;
  } aluctrl;

  typedef struct packed {
    logic GT;
    logic ET;
  } flg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    HOLD = 2'd3
  } aluState;

  typedef enum logic [3:0] {
    OP_NONE, OP_ADD, OP_SUB, OP_CMP, OP_MUL, OP_DIV, OP_MOD,
    OP_LSL, OP_LSR, OP_ASR, OP_OR, OP_AND, OP_NOT, OP_MOV
  } aluOp;

  // The decoder may raise several bits at once; the earliest one in this chain wins.
  function automatic aluOp decodeOp(input aluctrl c);
    aluOp op;
    if      (c.isAdd) op = OP_ADD;
    else if (c.isSub) op = OP_SUB;
    else if (c.isCmp) op = OP_CMP;
    else if (c.isMul) op = OP_MUL;
    else if (c.isDiv) op = OP_DIV;
    else if (c.isMod) op = OP_MOD;
    else if (c.isLsl) op = OP_LSL;
    else if (c.isLsr) op = OP_LSR;
    else if (c.isAsr) op = OP_ASR;
    else if (c.isOr)  op = OP_OR;
    else if (c.isAnd) op = OP_AND;
    else if (c.isNot) op = OP_NOT;
    else if (c.isMov) op = OP_MOV;
    else              op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH clocks after start.
// quotient/remainder show the values being committed this cycle, valid when done is high.
module alu_div_iter
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divReg;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remTrial;

  // Dividend bits leave quoReg at the top while quotient bits enter at the bottom.
  always_comb begin
    remShift = {remReg, quoReg[WIDTH-1]};
    remTrial = remShift - {1'b0, divReg};
    if (!remTrial[WIDTH]) begin
      remainder = remTrial[WIDTH-1:0];
      quotient  = {quoReg[WIDTH-2:0], 1'b1};
    end else begin
      remainder = remShift[WIDTH-1:0];
      quotient  = {quoReg[WIDTH-2:0], 1'b0};
    end
    done = running && (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      remReg  <= '0;
      quoReg  <= '0;
      divReg  <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      remReg  <= '0;
      quoReg  <= dividend;
      divReg  <= divisor;
    end else if (running) begin
      remReg <= remainder;
      quoReg <= quotient;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle logic/arith ops,
// iterative shift-add multiply and restoring divide/modulo.
module alu_exec
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  aluctrl           ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output flg               flags,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  aluState          state;
  aluState          stateNext;
  aluOp             opSel;
  logic             accept;
  logic             outValidNext;
  logic [WIDTH-1:0] resultNext;
  flg               flagsNext;
  logic             startDiv;
  logic             divIsMod;
  logic [WIDTH-1:0] mulA;
  logic [WIDTH-1:0] mulB;
  logic [WIDTH-1:0] mulAcc;
  logic [WIDTH-1:0] mulSum;
  logic [CW-1:0]    iterCnt;
  logic [WIDTH-1:0] divQuo;
  logic [WIDTH-1:0] divRem;
  logic             divDone;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == MUL) || (state == DIV);
  assign opSel    = decodeOp(ctrl);
  assign mulSum   = mulAcc + (mulB[0] ? mulA : '0);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    stateNext    = state;
    resultNext   = result;
    flagsNext    = flags;
    outValidNext = out_valid && !out_ready;
    startDiv     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          outValidNext = 1'b1;
          case (opSel)
            OP_ADD: resultNext = op_a + op_b;
            OP_SUB: resultNext = op_a - op_b;
            OP_CMP: begin
              resultNext   = '0;
              flagsNext.GT = $signed(op_a) > $signed(op_b);
              flagsNext.ET = (op_a == op_b);
            end
            OP_MUL: begin
              outValidNext = 1'b0;
              stateNext    = MUL;
            end
            OP_DIV, OP_MOD: begin
              // A zero divisor is answered at once instead of iterating.
              if (op_b == '0) begin
                resultNext = (opSel == OP_DIV) ? '1 : op_a;
              end else begin
                outValidNext = 1'b0;
                stateNext    = DIV;
                startDiv     = 1'b1;
              end
            end
            OP_LSL:  resultNext = op_a << op_b[CW-1:0];
            OP_LSR:  resultNext = op_a >> op_b[CW-1:0];
            OP_ASR:  resultNext = $signed(op_a) >>> op_b[CW-1:0];
            OP_OR:   resultNext = op_a | op_b;
            OP_AND:  resultNext = op_a & op_b;
            OP_NOT:  resultNext = ~op_a;
            OP_MOV:  resultNext = op_b;
            default: resultNext = '0;
          endcase
        end
      end
      MUL: begin
        if (iterCnt == LAST) begin
          resultNext   = mulSum;
          outValidNext = 1'b1;
          stateNext    = HOLD;
        end
      end
      DIV: begin
        if (divDone) begin
          resultNext   = divIsMod ? divRem : divQuo;
          outValidNext = 1'b1;
          stateNext    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      state     <= stateNext;
      out_valid <= outValidNext;
      result    <= resultNext;
      flags     <= flagsNext;
    end
  end

  // Operands are captured on every acceptance; only MUL/DIV use them afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mulA     <= '0;
      mulB     <= '0;
      mulAcc   <= '0;
      iterCnt  <= '0;
      divIsMod <= 1'b0;
    end else if (accept) begin
      mulA     <= op_a;
      mulB     <= op_b;
      mulAcc   <= '0;
      iterCnt  <= '0;
      divIsMod <= (opSel == OP_MOD);
    end else if (state == MUL) begin
      mulAcc  <= mulSum;
      mulA    <= mulA << 1;
      mulB    <= mulB >> 1;
      iterCnt <= iterCnt + 1'b1;
    end
  end

  alu_div_iter #(
    .WIDTH(WIDTH)
  ) uDiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (startDiv),
    .divisor  (op_b),
    .dividend (op_a),
    .quotient (divQuo),
    .remainder(divRem),
    .done     (divDone)
  );

endmodule
